// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, receiver FSM encoding and FIFO entry layout shared by the UART receiver
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       parity_err;
        logic       frame_err;
    } rx_entry_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_ext_if.sv
// uart_rx_ext_if: receive-side read port of the UART; master is the receiver, slave the consumer
interface uart_rx_ext_if;

    logic       i_Rd_En;
    logic       o_Rx_Valid;
    logic [7:0] o_Rx_Byte;
    logic       o_Parity_Err;
    logic       o_Frame_Err;
    logic       o_Break;
    logic       o_Overrun;

    modport master (
        input  i_Rd_En,
        output o_Rx_Valid, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Overrun
    );

    modport slave (
        output i_Rd_En,
        input  o_Rx_Valid, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Overrun
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with head-of-queue output, zero while empty; flags pushes it had to drop
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic             full, do_pop, do_push;

    assign empty   = wr_q == rd_q;
    assign full    = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign do_pop  = pop & ~empty;
    // when full, a same-cycle pop frees the slot the write lands in
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;
    assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + PW'(do_push);
        rd_d = rd_q + PW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampling UART receiver with 2-of-3 bit voting, parity/frame/break detection
// and a receive FIFO read through uart_rx_ext_if
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          i_Clock,
    input  logic          i_Rst_n,
    input  logic          i_Rx_Serial,
    uart_rx_ext_if.master bus
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SMP       = CW'((CLKS_PER_BIT - 1) / 2 + 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d, hist_q, hist_d, live_q, live_d;
    logic          arm_q, arm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d, ferr_q, ferr_d;
    logic          push_q, push_d, brk_q, brk_d, ovr_q;
    rx_entry_t     entry_q, entry_d, head;
    logic          rx, smp, bit_end, bit_v, is_brk, perr, empty, drop;

    assign rx      = sync_q[1];
    assign smp     = cnt_q == SMP;
    assign bit_end = cnt_q == LAST;
    // hist holds the samples from counts MID-1 and MID; rx is the MID+1 sample
    assign bit_v   = maj3(hist_q[1], hist_q[0], rx);
    assign is_brk  = idx_q == '0 && data_q == '0 && (PARITY == PAR_NONE || !par_q) && !bit_v;
    assign perr    = PARITY != PAR_NONE && ((^data_q ^ par_q) != (PARITY == PAR_ODD));

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (arm_q && !rx) state_d = ST_START;
            ST_START:      if (smp && bit_v) state_d = ST_IDLE;
                           else if (bit_end) state_d = ST_DATA;
            ST_DATA:       if (bit_end && idx_q == LAST_DATA) state_d = PARITY != PAR_NONE ? ST_PARITY : ST_STOP;
            ST_PARITY:     if (bit_end) state_d = ST_STOP;
            ST_STOP:       if (smp) state_d = is_brk ? ST_BREAK_WAIT : idx_q == LAST_STOP ? ST_IDLE : ST_STOP;
            ST_BREAK_WAIT: if (rx) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // arm stays low after reset until a genuinely synchronised high is seen, so a
    // line held low across reset cannot start a frame
    always_comb begin
        sync_d  = {sync_q[0], i_Rx_Serial};
        hist_d  = {hist_q[0], rx};
        live_d  = {live_q[0], 1'b1};
        arm_d   = arm_q | (live_q[1] & rx);
        cnt_d   = (state_d == ST_IDLE || state_d == ST_BREAK_WAIT) ? '0 :
                  state_q == ST_IDLE ? CW'(1) : bit_end ? '0 : cnt_q + CW'(1);
        idx_d   = !bit_end ? idx_q : state_d == state_q ? idx_q + 3'd1 : '0;
        data_d  = data_q;
        if (state_q == ST_IDLE) data_d = '0;
        else if (state_q == ST_DATA && smp) data_d[idx_q] = bit_v;
        par_d   = (state_q == ST_PARITY && smp) ? bit_v : par_q;
        ferr_d  = state_q == ST_IDLE ? 1'b0 : ferr_q | (state_q == ST_STOP && smp && !bit_v);
        push_d  = state_q == ST_STOP && smp && (is_brk || idx_q == LAST_STOP);
        brk_d   = state_q == ST_STOP && smp && is_brk;
        entry_d = {data_q, perr, ferr_q | ~bit_v};
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_q  <= '1;
            hist_q  <= '1;
            live_q  <= '0;
            arm_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            push_q  <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
            entry_q <= '0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            live_q  <= live_d;
            arm_q   <= arm_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
            push_q  <= push_d;
            brk_q   <= brk_d;
            ovr_q   <= drop;
            entry_q <= entry_d;
        end
    end

    uart_rx_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_Clock),
        .rst_n (i_Rst_n),
        .push  (push_q),
        .din   (entry_q),
        .pop   (bus.i_Rd_En),
        .dout  (head),
        .empty (empty),
        .drop  (drop)
    );

    assign bus.o_Rx_Valid   = !empty;
    assign bus.o_Rx_Byte    = head.data;
    assign bus.o_Parity_Err = head.parity_err;
    assign bus.o_Frame_Err  = head.frame_err;
    assign bus.o_Break      = brk_q;
    assign bus.o_Overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: random and directed frames into 8N1, 7E1 and 8N2 receivers, checked against
// a frame-level model of the expected FIFO contents and pulse counts
module tb_uart_rx_ext;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int NB [3] = '{8, 7, 8};
    localparam int PM [3] = '{PAR_NONE, PAR_EVEN, PAR_NONE};
    localparam int NS [3] = '{1, 1, 2};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx [3];
    int   checks = 0;
    int   errors = 0;
    int   brk_cnt [3];
    int   ovr_cnt [3];
    int   brk_exp [3];
    int   ovr_exp [3];
    logic [9:0] mq [$];

    uart_rx_ext_if b0 ();
    uart_rx_ext_if b1 ();
    uart_rx_ext_if b2 ();

    uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
        u0 (.i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[0]), .bus(b0));
    uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
        u1 (.i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[1]), .bus(b1));
    uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
        u2 (.i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx[2]), .bus(b2));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (b0.o_Break)   brk_cnt[0]++;
        if (b1.o_Break)   brk_cnt[1]++;
        if (b2.o_Break)   brk_cnt[2]++;
        if (b0.o_Overrun) ovr_cnt[0]++;
        if (b1.o_Overrun) ovr_cnt[1]++;
        if (b2.o_Overrun) ovr_cnt[2]++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic peek(input int u, output logic v, output logic [7:0] b, output logic pe, output logic fe);
        case (u)
            0:       begin v = b0.o_Rx_Valid; b = b0.o_Rx_Byte; pe = b0.o_Parity_Err; fe = b0.o_Frame_Err; end
            1:       begin v = b1.o_Rx_Valid; b = b1.o_Rx_Byte; pe = b1.o_Parity_Err; fe = b1.o_Frame_Err; end
            default: begin v = b2.o_Rx_Valid; b = b2.o_Rx_Byte; pe = b2.o_Parity_Err; fe = b2.o_Frame_Err; end
        endcase
    endtask

    task automatic set_rd(input int u, input logic v);
        case (u)
            0:       b0.i_Rd_En = v;
            1:       b1.i_Rd_En = v;
            default: b2.i_Rd_En = v;
        endcase
    endtask

    // Expected receiver result for one frame; a full FIFO drops the frame and counts an overrun
    task automatic model_push(input int u, input logic [7:0] d, input logic pe, input logic fe, input logic brk);
        if (brk) brk_exp[u]++;
        if (mq.size() < DEPTH) mq.push_back({d, pe, fe});
        else ovr_exp[u]++;
    endtask

    // bad_stop holds the first stop bit low for its first 10 clocks, then idles two bit periods
    task automatic send_frame(input int u, input logic [7:0] data, input bit bad_par, input bit bad_stop,
                              input int gbit, input int gcyc);
        logic [7:0] mask;
        logic [7:0] d;
        logic       pb;
        bit         bits [$];
        int         stop0;
        mask  = 8'hFF >> (8 - NB[u]);
        d     = data & mask;
        pb    = (^d) ^ (PM[u] == PAR_ODD) ^ bad_par;
        stop0 = 1 + NB[u] + (PM[u] != PAR_NONE ? 1 : 0);
        bits.push_back(1'b0);
        for (int i = 0; i < NB[u]; i++) bits.push_back(d[i]);
        if (PM[u] != PAR_NONE) bits.push_back(pb);
        for (int i = 0; i < NS[u]; i++) bits.push_back(1'b1);
        for (int i = 0; i < bits.size(); i++) begin
            for (int c = 0; c < CPB; c++) begin
                bit v;
                v = bits[i];
                if (gbit >= 0 && i == 1 + gbit && c == gcyc) v = ~v;
                if (bad_stop && i == stop0 && c < 10) v = 1'b0;
                rx[u] = v;
                @(negedge clk);
            end
        end
        rx[u] = 1'b1;
        if (bad_stop) repeat (2 * CPB) @(negedge clk);
        model_push(u, d, PM[u] != PAR_NONE && bad_par, bad_stop,
                   bad_stop && d == 8'h00 && (PM[u] == PAR_NONE || pb == 1'b0));
    endtask

    task automatic drain(input int u, input string tag);
        logic       v, pe, fe;
        logic [7:0] b;
        logic [9:0] e;
        int         n;
        repeat (4) @(negedge clk);
        chk($sformatf("%s.break_pulses", tag), brk_cnt[u], brk_exp[u]);
        chk($sformatf("%s.overrun_pulses", tag), ovr_cnt[u], ovr_exp[u]);
        n = 0;
        while (mq.size() > 0) begin
            e = mq.pop_front();
            peek(u, v, b, pe, fe);
            chk($sformatf("%s[%0d].valid", tag, n), v, 1);
            chk($sformatf("%s[%0d].byte", tag, n), b, e[9:2]);
            chk($sformatf("%s[%0d].parity_err", tag, n), pe, e[1]);
            chk($sformatf("%s[%0d].frame_err", tag, n), fe, e[0]);
            set_rd(u, 1'b1);
            @(negedge clk);
            set_rd(u, 1'b0);
            n++;
        end
        peek(u, v, b, pe, fe);
        chk($sformatf("%s.empty_valid", tag), v, 0);
        chk($sformatf("%s.empty_byte", tag), b, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic       v, pe, fe;
        logic [7:0] b;
        for (int u = 0; u < 3; u++) begin
            rx[u] = 1'b1;
            set_rd(u, 1'b0);
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            peek(u, v, b, pe, fe);
            chk($sformatf("reset%0d.valid", u), v, 0);
            chk($sformatf("reset%0d.byte", u), b, 0);
            chk($sformatf("reset%0d.errs", u), {pe, fe}, 0);
        end
        chk("reset.pulses", {b0.o_Break, b0.o_Overrun, b1.o_Break, b1.o_Overrun, b2.o_Break, b2.o_Overrun}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(0, 8'hA5, 0, 0, -1, 0);
        drain(0, "8n1_a5");
        for (int i = 0; i < 12; i++) begin
            send_frame(0, 8'($urandom), 0, $urandom_range(0, 4) == 0,
                       $urandom_range(0, 3) != 0 ? int'($urandom_range(0, 7)) : -1, int'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) drain(0, "8n1_rand");
        end
        drain(0, "8n1_rand_end");

        send_frame(1, 8'h41, 1, 0, -1, 0);
        send_frame(1, 8'h41, 0, 0, -1, 0);
        drain(1, "7e1_41");
        for (int i = 0; i < 8; i++)
            send_frame(1, 8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                       int'($urandom_range(0, 6)), int'($urandom_range(0, 15)));
        drain(1, "7e1_rand");

        rx[0] = 1'b0;
        repeat (3) @(negedge clk);
        rx[0] = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        drain(0, "glitch");
        send_frame(0, 8'h5A, 0, 0, 2, (CPB - 1) / 2);
        drain(0, "majority");

        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 0, 0, -1, 0);
        drain(0, "overrun");

        rx[2] = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        model_push(2, 8'h00, 1'b0, 1'b1, 1'b1);
        drain(2, "break_low");
        rx[2] = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        drain(2, "break_high");
        for (int i = 0; i < 6; i++)
            send_frame(2, 8'($urandom), 0, $urandom_range(0, 4) == 0, -1, 0);
        drain(2, "8n2_rand");

        send_frame(0, 8'h77, 0, 0, -1, 0);
        rx[0] = 1'b0;
        repeat (4 * CPB + 5) @(negedge clk);
        rst_n = 1'b0;
        mq.delete();
        repeat (3) @(negedge clk);
        peek(0, v, b, pe, fe);
        chk("midreset.valid", v, 0);
        chk("midreset.byte", b, 0);
        rst_n = 1'b1;
        repeat (5 * CPB - 5) @(negedge clk);
        rx[0] = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_frame(0, 8'h3C, 0, 0, -1, 0);
        drain(0, "midreset_3c");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clocks per bit period; legal range 16..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal 5..8.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; power of 2, at least 2.
REQ-006 SHALL have port i_Clock  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port i_Rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-008 SHALL have port i_Rx_Serial  in  1  asynchronous serial line; idles high.
REQ-009 SHALL have port i_Rd_En  in  1  pops the FIFO head when o_Rx_Valid=1.
REQ-010 SHALL have port o_Rx_Valid  out  1  FIFO non-empty.
REQ-011 SHALL have port o_Rx_Byte  out  8  FIFO head data, LSB-first assembled, unused upper bits 0.
REQ-012 SHALL have port o_Parity_Err  out  1  head entry failed parity; 0 when PARITY=0.
REQ-013 SHALL have port o_Frame_Err  out  1  head entry had a low stop-bit sample.
REQ-014 SHALL have port o_Break  out  1  one-cycle pulse on break detection.
REQ-015 SHALL have port o_Overrun  out  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-016 SHALL pass i_Rx_Serial through a 2-flop synchroniser, both flops resetting to 1; all sampling uses the second flop.
REQ-017 SHALL sample each bit as the 2-of-3 majority of synchronised values at counts MID-1, MID, MID+1, with MID=(CLKS_PER_BIT-1)/2 measured from the bit's start edge.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-019 SHALL go IDLE->START on a synchronised low; START->IDLE with no push if the start-bit majority is 1; START->DATA otherwise.
REQ-020 SHALL go DATA->PARITY after DATA_BITS samples if PARITY!=0, else DATA->STOP.
REQ-021 SHALL compute parity error as XOR of data bits and parity bit: =1 for even, =0 for odd.
REQ-022 SHALL, in STOP, check STOP_BITS stop bits; frame error if any sample is 0.
REQ-023 SHALL push {byte, parity_err, frame_err} one cycle after the final stop sample and return to IDLE in that cycle, not waiting for the end of the stop bit.
REQ-024 SHALL, when all data bits, the parity bit if present, and the first stop sample are 0, push the entry with frame_err=1, pulse o_Break, enter BREAK_WAIT, and return to IDLE only after a synchronised 1.
REQ-025 SHALL assert o_Rx_Valid on the cycle after the push, for zero-latency FIFO output.
REQ-026 SHALL accept a push while full only with a simultaneous pop; otherwise drop the new frame, keep existing entries, and pulse o_Overrun.
REQ-027 SHALL ignore i_Rd_En when empty; simultaneous push and pop when empty SHALL leave the new entry at the head.
REQ-028 SHALL use a FIFO pointer width of $clog2(FIFO_DEPTH)+1 so full/empty are distinguished; pointers wrap naturally.
REQ-029 SHALL size the bit counter as $clog2(CLKS_PER_BIT) bits; no truncation at CLKS_PER_BIT=65535.

Reset
REQ-030 SHALL, while i_Rst_n=0, force FSM=IDLE, counters=0, FIFO empty, o_Rx_Valid=0, o_Rx_Byte=0, all error and pulse outputs 0, and synchroniser=1.
REQ-031 SHALL, on reset mid-frame, discard the partial frame; after release the first frame SHALL be received only after a fresh falling edge.

Structure
REQ-032 SHALL place the parity-mode constants (PAR_NONE/EVEN/ODD) and the FSM state encoding in the shared package uart_pkg.
REQ-033 SHALL instantiate one sub-module, uart_rx_fifo: synchronous FIFO, parameterised width and depth.

Verification
REQ-034 SHALL verify, at CLKS_PER_BIT=16, 8N1: send 0xA5 -> o_Rx_Valid rises, o_Rx_Byte=0xA5, both error flags 0.
REQ-035 SHALL verify 7E1: send 0x41 with a wrong parity bit -> o_Rx_Byte=0x41, o_Parity_Err=1; with correct parity -> 0.
REQ-036 SHALL verify a 3-cycle low glitch on an idle line -> no push; a single-cycle inverted sample mid data bit -> byte unchanged (majority vote).
REQ-037 SHALL verify, at FIFO_DEPTH=4, five back-to-back frames 0x01..0x05 with no reads -> one o_Overrun pulse; pops return 0x01..0x04.
REQ-038 SHALL verify 8N2: line low for 12 bit periods -> entry 0x00 with o_Frame_Err=1, one o_Break pulse; no further push until the line returns high.
REQ-039 SHALL verify reset asserted during data bit 3, then 0x3C sent -> only 0x3C received.
